// File: rtl/pingpong_operand_buffer.sv
// -----------------------------------------------------------------------------
// pingpong_operand_buffer
//
// Double-banked operand store for the MAC datapath. The producer fills the
// write bank while the MAC array reads the other bank through NUM_RD
// combinational read ports. A bank passes from the producer to the consumer on
// wr_commit and comes back on rd_release. Banks are consumed in commit order.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   wr_en           write strobe, accepted only while wr_ready and in range
//   wr_addr         write address within the current write bank
//   wr_data         write data
//   wr_commit       hands the current write bank over to the consumer
//   wr_ready        current write bank is free
//   wr_bank         index of the current write bank
//   rd_addr         packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data         packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_valid        current read bank holds committed data
//   rd_release      consumer is done with the current read bank
//   rd_bank         index of the current read bank
//   drop_cnt        saturating count of cycles with a rejected write/commit
//                   (present only when PINGPONG_DROP_CNT_EN is defined)
//
// Optional feature macro: PINGPONG_DROP_CNT_EN
// -----------------------------------------------------------------------------
module pingpong_operand_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_commit,
    output logic                     wr_ready,
    output logic                     wr_bank,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     rd_release,
    output logic                     rd_bank
`ifdef PINGPONG_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    // One extra bit so DEPTH == 2**ADDR_W still fits in the compare.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [1:0]        full;
    logic              wr_ptr;
    logic              rd_ptr;

    logic wr_in_range;
    logic wr_accept;
    logic commit_ok;
    logic release_ok;

    assign wr_ready    = !full[wr_ptr];
    assign rd_valid    = full[rd_ptr];
    assign wr_bank     = wr_ptr;
    assign rd_bank     = rd_ptr;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign wr_accept   = wr_en && wr_ready && wr_in_range;
    assign commit_ok   = wr_commit && wr_ready;
    assign release_ok  = rd_release && rd_valid;

    // An accepted commit needs full[wr_ptr]=0 and an accepted release needs
    // full[rd_ptr]=1, so the two updates below never touch the same bit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the storage is reset as well because a freshly reset buffer must
    // read back zeros, not power-up garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem[b][e] <= '0;
                end
            end
            full   <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            // Write lands before the commit moves wr_ptr, so a same-cycle
            // write goes into the bank being committed.
            if (wr_accept) begin
                mem[wr_ptr][wr_addr] <= wr_data;
            end
            if (commit_ok) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
            end
            if (release_ok) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
    end

    // Zero-latency read ports; out-of-range or not-yet-committed reads give 0.
    // NOTE: rd_data gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_valid && ({1'b0, rd_addr[i*ADDR_W +: ADDR_W]} < DEPTH_L)) begin
                rd_data[i*DATA_W +: DATA_W] = mem[rd_ptr][rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

`ifdef PINGPONG_DROP_CNT_EN
    logic drop_evt;

    // One count per cycle, however many reasons the cycle had to reject.
    assign drop_evt = ((wr_en || wr_commit) && !wr_ready) || (wr_en && !wr_in_range);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 16'h0000;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_operand_buffer.sv
// -----------------------------------------------------------------------------
// tb_pingpong_operand_buffer
//
// Drives a DEPTH=4 and a DEPTH=3 instance with identical stimulus and compares
// both against a reference model that tracks commit/release counts: the write
// bank is commits%2, the read bank is releases%2, and the number of full banks
// is commits-releases.
// -----------------------------------------------------------------------------
module tb_pingpong_operand_buffer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_commit;
    logic [3:0]  rd_addr;
    logic        rd_release;

    logic [1:0]  wr_ready_s;
    logic [1:0]  wr_bank_s;
    logic [1:0]  rd_valid_s;
    logic [1:0]  rd_bank_s;
    logic [15:0] rd_data_s [2];
`ifdef PINGPONG_DROP_CNT_EN
    logic [15:0] drop_s [2];
`endif

    pingpong_operand_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .NUM_RD(2)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready_s[0]),
        .wr_bank    (wr_bank_s[0]),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_s[0]),
        .rd_valid   (rd_valid_s[0]),
        .rd_release (rd_release),
        .rd_bank    (rd_bank_s[0])
`ifdef PINGPONG_DROP_CNT_EN
        ,
        .drop_cnt   (drop_s[0])
`endif
    );

    pingpong_operand_buffer #(.DATA_W(8), .DEPTH(3), .ADDR_W(2), .NUM_RD(2)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready_s[1]),
        .wr_bank    (wr_bank_s[1]),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_s[1]),
        .rd_valid   (rd_valid_s[1]),
        .rd_release (rd_release),
        .rd_bank    (rd_bank_s[1])
`ifdef PINGPONG_DROP_CNT_EN
        ,
        .drop_cnt   (drop_s[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, index k: 0 = DEPTH 4, 1 = DEPTH 3.
    logic [7:0] m_mem [2][2][4];
    int         n_commit  [2];
    int         n_release [2];
    int         m_drop    [2];

    int n_pass;
    int n_total;

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 2; b++)
                for (int e = 0; e < 4; e++)
                    m_mem[k][b][e] = 8'h00;
            n_commit[k]  = 0;
            n_release[k] = 0;
            m_drop[k]    = 0;
        end
    endtask

    // Applies one clock edge worth of the current inputs to the model.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int  occ;
            bit  ready;
            bit  valid;
            bit  in_range;
            occ      = n_commit[k] - n_release[k];
            ready    = (occ < 2);
            valid    = (occ > 0);
            in_range = (int'(wr_addr) < depth_of(k));
            if ((((wr_en || wr_commit) && !ready) || (wr_en && !in_range)) && m_drop[k] < 65535)
                m_drop[k]++;
            if (wr_en && ready && in_range)
                m_mem[k][n_commit[k] % 2][wr_addr] = wr_data;
            if (wr_commit && ready)
                n_commit[k]++;
            if (rd_release && valid)
                n_release[k]++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int occ;
            occ = n_commit[k] - n_release[k];
            check($sformatf("wr_ready[%0d]", k), 32'(wr_ready_s[k]), 32'(occ < 2));
            check($sformatf("rd_valid[%0d]", k), 32'(rd_valid_s[k]), 32'(occ > 0));
            check($sformatf("wr_bank[%0d]", k),  32'(wr_bank_s[k]),  32'(n_commit[k] % 2));
            check($sformatf("rd_bank[%0d]", k),  32'(rd_bank_s[k]),  32'(n_release[k] % 2));
            for (int i = 0; i < 2; i++) begin
                int         a;
                logic [7:0] e;
                a = int'(rd_addr[i*2 +: 2]);
                e = (occ > 0 && a < depth_of(k)) ? m_mem[k][n_release[k] % 2][a] : 8'h00;
                check($sformatf("rd_data[%0d][%0d]", k, i), 32'(rd_data_s[k][i*8 +: 8]), 32'(e));
            end
`ifdef PINGPONG_DROP_CNT_EN
            check($sformatf("drop_cnt[%0d]", k), 32'(drop_s[k]), 32'(m_drop[k]));
`endif
        end
    endtask

    // Sets inputs away from the edge, clocks once, then checks 1 time unit later.
    task automatic cyc(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic wc, input logic rr);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        wr_commit  = wc;
        rd_release = rr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        wr_en      = 1'b0;
        wr_commit  = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic set_rd(input logic [1:0] a1, input logic [1:0] a0);
        rd_addr = {a1, a0};
        #1;
        check_all();
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 8'h00;
        wr_commit  = 1'b0;
        rd_addr    = 4'h0;
        rd_release = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_wr_ready", 32'(wr_ready_s[0]), 32'd1);
        check("reset_rd_data", 32'(rd_data_s[0]), 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Fill bank 0 (DEPTH 3 instance drops addr3), commit.
        cyc(1, 2'd0, 8'h11, 0, 0);
        cyc(1, 2'd1, 8'h22, 0, 0);
        cyc(1, 2'd2, 8'h33, 0, 0);
        cyc(1, 2'd3, 8'h44, 0, 0);
        cyc(0, 2'd0, 8'h00, 1, 0);
        check("t1_rd_valid", 32'(rd_valid_s[0]), 32'd1);
        check("t1_rd_bank",  32'(rd_bank_s[0]),  32'd0);
        check("t1_wr_bank",  32'(wr_bank_s[0]),  32'd1);
        check("t1_wr_ready", 32'(wr_ready_s[0]), 32'd1);
        set_rd(2'd3, 2'd0);
        check("t1_rd_data",  32'(rd_data_s[0]), 32'h4411);
        check("t5_d3_addr3", 32'(rd_data_s[1]), 32'h0011);
`ifdef PINGPONG_DROP_CNT_EN
        check("t5_d3_drop",  32'(drop_s[1]), 32'd1);
`endif

        // Fill bank 1, commit without releasing, then a dropped write.
        cyc(1, 2'd0, 8'hA0, 0, 0);
        cyc(1, 2'd1, 8'hA1, 0, 0);
        cyc(1, 2'd2, 8'hA2, 0, 0);
        cyc(1, 2'd3, 8'hA3, 1, 0);
        check("t2_wr_ready_full", 32'(wr_ready_s[0]), 32'd0);
        cyc(1, 2'd0, 8'hFF, 0, 0);
        cyc(0, 2'd0, 8'h00, 0, 1);
        check("t2_rd_bank", 32'(rd_bank_s[0]), 32'd1);
        check("t2_wr_ready_freed", 32'(wr_ready_s[0]), 32'd1);
        set_rd(2'd0, 2'd0);
        check("t2_rd_data", 32'(rd_data_s[0]), 32'hA0A0);

        // Write and commit in the same cycle into bank 0, then release bank 1.
        cyc(1, 2'd2, 8'h5A, 1, 0);
        cyc(0, 2'd0, 8'h00, 0, 1);
        set_rd(2'd2, 2'd2);
        check("t3_same_cycle_wr", 32'(rd_data_s[0]), 32'h5A5A);

        // Commit bank 1 while releasing bank 0.
        cyc(0, 2'd0, 8'h00, 1, 1);
        check("t4_rd_bank",  32'(rd_bank_s[0]),  32'd1);
        check("t4_rd_valid", 32'(rd_valid_s[0]), 32'd1);
        check("t4_wr_bank",  32'(wr_bank_s[0]),  32'd0);
        check("t4_wr_ready", 32'(wr_ready_s[0]), 32'd1);

        // Commit bank 0 too, then assert reset mid-operation.
        cyc(1, 2'd1, 8'h77, 1, 0);
        cyc(1, 2'd0, 8'h66, 0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_wr_ready", 32'(wr_ready_s[0]), 32'd1);
        check("t6_rd_valid", 32'(rd_valid_s[0]), 32'd0);
        check("t6_rd_data",  32'(rd_data_s[0]),  32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 2'd0, 8'h00, 0, 1);
        check("t6_release_ignored", 32'(rd_bank_s[0]), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rd_addr = 4'($urandom);
            cyc(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pingpong_operand_buffer.md
Name: pingpong_operand_buffer

Overview:
Double-banked (ping-pong) operand store for the MAC datapath. The producer fills one bank while the MAC array reads the other through NUM_RD independent combinational read ports. Bank ownership passes between the two sides by a commit/release handshake, so loading the next operand set overlaps computation on the current one. This block is the parametrised successor of the single-bank, two-read-port operand register file.

Parameters:
DATA_W, 8, bits per entry
DEPTH, 4, entries per bank (need not be a power of two)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH
NUM_RD, 2, number of read ports (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address within the current write bank
wr_data  input  DATA_W  write data
wr_commit  input  1  producer marks the current write bank as complete
wr_ready  output  1  current write bank is free (writes and commit accepted)
wr_bank  output  1  index of the current write bank
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
rd_valid  output  1  current read bank holds committed data
rd_release  input  1  consumer has finished with the current read bank
rd_bank  output  1  index of the current read bank

Behaviour:
- State: mem[2][DEPTH], full[1:0], wr_ptr, rd_ptr.
- Reset (async, rst=1): all mem entries 0, full=2'b00, wr_ptr=0, rd_ptr=0.
  - Resulting outputs: wr_ready=1, rd_valid=0, wr_bank=0, rd_bank=0, rd_data all 0.
- Status outputs (combinational):
  - wr_ready = !full[wr_ptr].
  - rd_valid = full[rd_ptr].
  - wr_bank = wr_ptr; rd_bank = rd_ptr.
- Write: on posedge, if wr_en && wr_ready && wr_addr<DEPTH, then mem[wr_ptr][wr_addr] <= wr_data.
  - Write while !wr_ready: dropped, no state change.
  - wr_addr>=DEPTH: dropped.
- Commit: on posedge, if wr_commit && wr_ready, then full[wr_ptr] <= 1 and wr_ptr toggles.
  - wr_en and wr_commit in the same cycle: the write lands in the bank being committed.
  - Commit while !wr_ready: ignored.
- Read (combinational, zero latency):
  - rd_data[i] = mem[rd_ptr][rd_addr[i]] when rd_valid && rd_addr[i]<DEPTH; otherwise 0.
  - All ports may read the same address simultaneously.
- Release: on posedge, if rd_release && rd_valid, then full[rd_ptr] <= 0 and rd_ptr toggles.
  - Release while !rd_valid: ignored.
  - Released bank contents are retained, not cleared.
- Simultaneous commit and release in one cycle: both take effect. They always act on different banks, because an accepted commit needs full[wr_ptr]=0 and an accepted release needs full[rd_ptr]=1.
- Both banks full: wr_ready=0 until a release. The freed bank becomes writable the next cycle.
- Both banks empty: rd_valid=0. A commit makes rd_valid=1 the next cycle (1-cycle commit-to-read latency).
- Ordering: banks are consumed strictly in commit order; wr_ptr and rd_ptr each alternate 0,1,0,...
- Reset mid-operation: all state clears immediately; in-flight commits and releases are lost.

Optional Feature:
Macro PINGPONG_DROP_CNT_EN.
- Defined: adds output drop_cnt [15:0]. It increments by 1 per cycle in which (wr_en || wr_commit) && !wr_ready, or wr_en && wr_addr>=DEPTH. It saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then write addr0..3 = 0x11,0x22,0x33,0x44, commit -> next cycle rd_valid=1, rd_bank=0, wr_bank=1, wr_ready=1; rd_addr={3,0} -> rd_data={0x44,0x11}.
- Fill and commit bank1 with 0xA0..0xA3 without releasing -> wr_ready=0; write 0xFF to addr0 -> dropped; release -> rd_bank=1, rd_data at addr0 = 0xA0; bank0 writable next cycle.
- Same-cycle wr_en(addr2, 0x5A) + wr_commit -> after the bank becomes the read bank, addr2 reads 0x5A.
- Same-cycle commit (bank1) and release (bank0) -> next cycle rd_bank=1, rd_valid=1, wr_bank=0, wr_ready=1.
- DEPTH=3 instance: write addr3 ignored; reading addr3 returns 0; with PINGPONG_DROP_CNT_EN, drop_cnt=1.
- Assert rst mid-fill with bank0 committed -> outputs immediately wr_ready=1, rd_valid=0, rd_data=0; rd_release with rd_valid=0 -> no change.
